// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core LSU (port 0)
// and a debug/DMA requester (port 1), with registered per-port load return.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_p0_req,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  input  logic [3:0]        i_p0_bmask,
  input  logic              i_p0_wren,
  input  logic              i_p1_req,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  input  logic [3:0]        i_p1_bmask,
  input  logic              i_p1_wren,
  output logic              o_p0_gnt,
  output logic              o_p0_rvalid,
  output logic [DATA_W-1:0] o_p0_rdata,
  output logic              o_p0_err,
  output logic              o_p1_gnt,
  output logic              o_p1_rvalid,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic              o_p1_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t r_state, w_state_next;
  logic   r_last, w_last_next;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
    end
  end

  // Reset forces the state to IDLE asynchronously, so the memory strobes
  // below drop immediately and an in-flight store never commits.
  always_comb begin
    w_state_next = IDLE;
    w_last_next  = r_last;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_bmask  = '0;
    o_mem_wren   = 1'b0;

    case ({i_p1_req, i_p0_req})
      2'b01:   w_state_next = OWN0;
      2'b10:   w_state_next = OWN1;
      2'b11:   w_state_next = r_last ? OWN0 : OWN1;
      default: w_state_next = IDLE;
    endcase

    if (w_state_next == OWN0) w_last_next = 1'b0;
    if (w_state_next == OWN1) w_last_next = 1'b1;

    case (r_state)
      OWN0: begin
        o_mem_addr  = i_p0_addr;
        o_mem_wdata = i_p0_wdata;
        o_mem_bmask = i_p0_bmask;
        o_mem_wren  = i_p0_wren;
      end
      OWN1: begin
        o_mem_addr  = i_p1_addr;
        o_mem_wdata = i_p1_wdata;
        o_mem_bmask = i_p1_bmask;
        o_mem_wren  = i_p1_wren;
      end
      default: ;
    endcase
  end

  logic [1:0] w_own, w_wren, w_aerr;

  assign w_own  = {r_state == OWN1, r_state == OWN0};
  assign w_wren = {i_p1_wren, i_p0_wren};
  // Only the low 2 KiB are backed by memory; anything above flags an error.
  assign w_aerr = {|i_p1_addr[ADDR_W-1:11], |i_p0_addr[ADDR_W-1:11]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              r_rvalid;
      logic              r_err;
      logic [DATA_W-1:0] r_rdata;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_rvalid <= 1'b0;
          r_err    <= 1'b0;
          r_rdata  <= '0;
        end else begin
          r_rvalid <= w_own[gi] & ~w_wren[gi];
          r_err    <= w_own[gi] & w_aerr[gi];
          if (w_own[gi] & ~w_wren[gi]) r_rdata <= i_mem_rdata;
        end
      end
    end
  endgenerate

  assign o_p0_gnt    = w_own[0];
  assign o_p1_gnt    = w_own[1];
  assign o_p0_rvalid = g_port[0].r_rvalid;
  assign o_p1_rvalid = g_port[1].r_rvalid;
  assign o_p0_err    = g_port[0].r_err;
  assign o_p1_err    = g_port[1].r_err;
  assign o_p0_rdata  = g_port[0].r_rdata;
  assign o_p1_rdata  = g_port[1].r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level owner/memory reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, wren, gnt, rvalid, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  bmask [2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;

  // Environment memory: combinational read, write on the clock edge,
  // only the low 2 KiB exist.
  logic [31:0] mem [0:1023];
  logic        bd_clr, bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_owner;
  int          m_last;
  bit          m_rv [2];
  bit          m_err [2];
  logic [31:0] m_rd [2];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr[31:11] == 21'd0) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_wren && mem_addr[31:11] == 21'd0) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  dmem_arbiter dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_p0_req    (req[0]),
    .i_p0_addr   (addr[0]),
    .i_p0_wdata  (wdata[0]),
    .i_p0_bmask  (bmask[0]),
    .i_p0_wren   (wren[0]),
    .i_p1_req    (req[1]),
    .i_p1_addr   (addr[1]),
    .i_p1_wdata  (wdata[1]),
    .i_p1_bmask  (bmask[1]),
    .i_p1_wren   (wren[1]),
    .o_p0_gnt    (gnt[0]),
    .o_p0_rvalid (rvalid[0]),
    .o_p0_rdata  (rdata[0]),
    .o_p0_err    (err[0]),
    .o_p1_gnt    (gnt[1]),
    .o_p1_rvalid (rvalid[1]),
    .o_p1_rdata  (rdata[1]),
    .o_p1_err    (err[1]),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_bmask (mem_bmask),
    .o_mem_wren  (mem_wren),
    .i_mem_rdata (mem_rdata)
  );

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    for (int n = 0; n < 2; n++) begin
      m_rv[n]  = 1'b0;
      m_err[n] = 1'b0;
      m_rd[n]  = 32'h0;
    end
  endtask

  // Advance one clock: the model consumes this cycle's requests and the
  // current owner's access, then time moves to just after the edge.
  task automatic tick();
    int nxt;
    for (int n = 0; n < 2; n++) begin
      m_rv[n]  = (m_owner == n) && !wren[n];
      m_err[n] = (m_owner == n) && (addr[n][31:11] != 21'd0);
      if (m_rv[n]) m_rd[n] = (addr[n][31:11] == 21'd0) ? ref_mem[addr[n][11:2]] : 32'h0;
      if (m_owner == n && wren[n] && addr[n][31:11] == 21'd0)
        ref_mem[addr[n][11:2]] = wdata[n];
    end
    case (req)
      2'b00:   nxt = -1;
      2'b01:   nxt = 0;
      2'b10:   nxt = 1;
      default: nxt = 1 - m_last;
    endcase
    m_owner = nxt;
    if (nxt >= 0) m_last = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req    = 2'b11;
    wren   = 2'b00;
    addr[0] = 32'h100; addr[1] = 32'h104;
    wdata[0] = 32'h0;  wdata[1] = 32'h0;
    bmask[0] = 4'h0;   bmask[1] = 4'h0;
    bd_clr = 1'b1; bd_we = 1'b0; bd_idx = 10'd0; bd_data = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[16] = 32'hDEADBEEF;
    @(posedge clk);
    bd_clr = 1'b0; bd_we = 1'b1; bd_idx = 10'd16; bd_data = 32'hDEADBEEF;
    @(posedge clk);
    bd_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp %b", {gnt, rvalid, err}, 6'b0);
    end
    checks++;
    if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", rdata[0], rdata[1]);
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_bmask, mem_wren} !== 69'b0) begin
      errors++; $display("FAIL reset_mem got addr %h wdata %h bmask %h wren %b exp all 0",
                         mem_addr, mem_wdata, mem_bmask, mem_wren);
    end
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++; $display("FAIL reset_first_gnt got %b exp %b", gnt, 2'b01);
    end
    $display("reset: first grant %b", gnt);
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_single_load();
    req[0] = 1'b1; addr[0] = 32'h40; bmask[0] = 4'b0100; wren[0] = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00) begin
      errors++; $display("FAIL load_req_cycle_gnt got %b exp %b", gnt, 2'b00);
    end
    tick();
    checks++;
    if (gnt !== 2'b01 || mem_addr !== 32'h40 || mem_bmask !== 4'b0100 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL load_grant got gnt %b addr %h bmask %b wren %b exp 01 00000040 0100 0",
                         gnt, mem_addr, mem_bmask, mem_wren);
    end
    req[0] = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b01 || rdata[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_rvalid got gnt %b rvalid %b rdata %h exp 00 01 deadbeef",
                         gnt, rvalid, rdata[0]);
    end
    tick();
    checks++;
    if (rvalid !== 2'b00 || rdata[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_hold got rvalid %b rdata %h exp 00 deadbeef", rvalid, rdata[0]);
    end
    $display("single load: rdata %h", rdata[0]);
  endtask

  task automatic test_contention();
    logic [1:0] prev;
    prev = 2'b00;
    addr[0] = 32'h40; addr[1] = 32'h44; wren = 2'b00;
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (gnt !== {m_owner == 1, m_owner == 0}) begin
        errors++; $display("FAIL contention_gnt cycle %0d got %b exp %b", i, gnt, {m_owner == 1, m_owner == 0});
      end
      checks++;
      if ((gnt[0] ^ gnt[1]) !== 1'b1) begin
        errors++; $display("FAIL contention_onehot cycle %0d got %b exp one-hot", i, gnt);
      end
      if (i > 0) begin
        checks++;
        if (gnt === prev || rvalid !== prev) begin
          errors++; $display("FAIL contention_alternate cycle %0d got gnt %b rvalid %b exp gnt !%b rvalid %b",
                             i, gnt, rvalid, prev, prev);
        end
      end
      $display("contention cycle %0d: gnt %b rvalid %b", i, gnt, rvalid);
      prev = gnt;
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_store_load();
    req[1] = 1'b1; addr[1] = 32'h80; wdata[1] = 32'h12345678; bmask[1] = 4'b1010; wren[1] = 1'b1;
    #1;
    checks++;
    if (mem_wren !== 1'b0) begin
      errors++; $display("FAIL store_pre_wren got %b exp 0", mem_wren);
    end
    tick();
    checks++;
    if (gnt !== 2'b10 || mem_wren !== 1'b1 || mem_addr !== 32'h80 ||
        mem_wdata !== 32'h12345678 || mem_bmask !== 4'b1010) begin
      errors++; $display("FAIL store_grant got gnt %b wren %b addr %h wdata %h bmask %b exp 10 1 00000080 12345678 1010",
                         gnt, mem_wren, mem_addr, mem_wdata, mem_bmask);
    end
    req[1] = 1'b0;
    req[0] = 1'b1; addr[0] = 32'h80; wren[0] = 1'b0; bmask[0] = 4'b1111;
    tick();
    checks++;
    if (gnt !== 2'b01 || rvalid[1] !== 1'b0 || err[1] !== 1'b0 || mem_wren !== 1'b0) begin
      errors++; $display("FAIL store_after got gnt %b rvalid1 %b err1 %b wren %b exp 01 0 0 0",
                         gnt, rvalid[1], err[1], mem_wren);
    end
    req[0] = 1'b0;
    tick();
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h12345678) begin
      errors++; $display("FAIL store_load_rdata got rvalid %b rdata %h exp 1 12345678", rvalid[0], rdata[0]);
    end
    $display("store/load: p0 read %h", rdata[0]);
    tick();
  endtask

  task automatic test_error();
    req[0] = 1'b1; addr[0] = 32'h0000_0800; wren[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    tick();
    checks++;
    if (err[0] !== 1'b1 || rvalid[0] !== 1'b1) begin
      errors++; $display("FAIL err_load got err %b rvalid %b exp 1 1", err[0], rvalid[0]);
    end
    req[1] = 1'b1; addr[1] = 32'h0001_0000; wren[1] = 1'b1; wdata[1] = 32'hA5A5A5A5;
    tick();
    checks++;
    if (gnt !== 2'b10 || err[0] !== 1'b0) begin
      errors++; $display("FAIL err_store_grant got gnt %b err0 %b exp 10 0", gnt, err[0]);
    end
    req[1] = 1'b0;
    tick();
    checks++;
    if (err[1] !== 1'b1 || rvalid[1] !== 1'b0) begin
      errors++; $display("FAIL err_store got err %b rvalid %b exp 1 0", err[1], rvalid[1]);
    end
    $display("error: store err pulse %b", err[1]);
    tick();
    checks++;
    if (err !== 2'b00) begin
      errors++; $display("FAIL err_clear got %b exp 00", err);
    end
  endtask

  task automatic test_reset_mid_store();
    req[1] = 1'b1; addr[1] = 32'h80; wdata[1] = 32'hCAFEF00D; wren[1] = 1'b1;
    tick();
    checks++;
    if (mem_wren !== 1'b1 || gnt !== 2'b10) begin
      errors++; $display("FAIL midrst_grant got wren %b gnt %b exp 1 10", mem_wren, gnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_wren !== 1'b0 || gnt !== 2'b00) begin
      errors++; $display("FAIL midrst_async got wren %b gnt %b exp 0 00", mem_wren, gnt);
    end
    req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (mem[32] !== 32'h12345678) begin
      errors++; $display("FAIL midrst_mem got %h exp 12345678", mem[32]);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || rvalid !== 2'b00) begin
      errors++; $display("FAIL midrst_idle got gnt %b rvalid %b exp 00 00", gnt, rvalid);
    end
    $display("reset mid-store: mem[0x80] %h", mem[32]);
  endtask

  task automatic test_random();
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        ew;
    for (int c = 0; c < 300; c++) begin
      for (int n = 0; n < 2; n++) begin
        req[n]   = ($urandom_range(0, 99) < 60);
        wren[n]  = $urandom_range(0, 1);
        addr[n]  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h800) : ($urandom_range(0, 511) * 4);
        wdata[n] = $urandom;
        bmask[n] = 4'($urandom);
      end
      #1;
      if (m_owner >= 0) begin
        ea = addr[m_owner]; ed = wdata[m_owner]; eb = bmask[m_owner]; ew = wren[m_owner];
      end else begin
        ea = 32'h0; ed = 32'h0; eb = 4'h0; ew = 1'b0;
      end
      checks++;
      if (gnt !== {m_owner == 1, m_owner == 0}) begin
        errors++; $display("FAIL rand_gnt cycle %0d got %b exp %b", c, gnt, {m_owner == 1, m_owner == 0});
      end
      checks++;
      if (mem_addr !== ea || mem_wdata !== ed || mem_bmask !== eb || mem_wren !== ew) begin
        errors++; $display("FAIL rand_mem cycle %0d got %h %h %h %b exp %h %h %h %b",
                           c, mem_addr, mem_wdata, mem_bmask, mem_wren, ea, ed, eb, ew);
      end
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (rvalid[n] !== m_rv[n] || err[n] !== m_err[n] || rdata[n] !== m_rd[n]) begin
          errors++; $display("FAIL rand_resp cycle %0d port %0d got rv %b err %b rdata %h exp %b %b %h",
                             c, n, rvalid[n], err[n], rdata[n], m_rv[n], m_err[n], m_rd[n]);
        end
      end
      $display("random cycle %0d: req %b gnt %b rvalid %b err %b", c, req, gnt, rvalid, err);
      tick();
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_store_load();
    test_error();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
